// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared constants, state encoding and status helpers for the UART/Wishbone bridge
package bridge_pkg;

    localparam logic [7:0] CMD_WRITE_DEF = 8'h57;
    localparam logic [7:0] CMD_READ_DEF  = 8'h52;
    localparam logic [7:0] RSP_OK        = 8'h4B;
    localparam logic [7:0] RSP_ERR       = 8'h45;
    localparam logic [7:0] RSP_TIMEOUT   = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_REQ,
        ST_WAIT,
        ST_RESP_HDR,
        ST_RESP_DATA
    } state_t;

    typedef enum logic [1:0] {
        BUS_OK,
        BUS_ERR,
        BUS_TIMEOUT
    } bus_status_t;

    function automatic logic [7:0] status_byte(input bus_status_t s);
        case (s)
            BUS_OK:  return RSP_OK;
            BUS_ERR: return RSP_ERR;
            default: return RSP_TIMEOUT;
        endcase
    endfunction

endpackage

// File: rtl/byte_shifter.sv
// rtl/byte_shifter.sv - 32-bit register that shifts bytes in (MSB first) or shifts them out from the top
module byte_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        shift_in,
    input  logic [7:0]  byte_in,
    input  logic        shift_out,
    output logic [31:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_in) begin
            data <= {data[23:0], byte_in};
        end else if (shift_out) begin
            data <= {data[23:0], 8'h00};
        end
    end

endmodule

// File: rtl/uart_wb_bridge.sv
// rtl/uart_wb_bridge.sv - UART byte command decoder driving a single pipelined Wishbone transfer per command
module uart_wb_bridge
    import bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] CMD_WRITE      = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_READ       = CMD_READ_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i,
    output logic        busy_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t      state;
    bus_status_t status;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0] sh_data;
    logic        sh_load;
    logic        sh_in;
    logic        sh_out;
    logic        tx_fire;
    logic        bus_done;
    logic        is_cmd;

    assign tx_fire = tx_valid_o & tx_ready_i;
    assign is_cmd  = (rx_byte_i == CMD_WRITE) || (rx_byte_i == CMD_READ);
    assign busy_o  = (state != ST_IDLE);

    // Responses only count once the strobe has been accepted (WAIT, or REQ with no stall).
    always_comb begin
        bus_done = 1'b0;
        if ((state == ST_WAIT) || (state == ST_REQ && !wb_stall_i)) begin
            bus_done = wb_ack_i | wb_err_i;
        end
        sh_in   = rx_valid_i && (state == ST_ADDR || state == ST_WDATA);
        sh_load = bus_done && wb_ack_i && !wb_err_i && !is_write;
        sh_out  = tx_fire && (state == ST_RESP_HDR || state == ST_RESP_DATA);
    end

    byte_shifter u_shifter (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .load      (sh_load),
        .load_data (wb_dat_i),
        .shift_in  (sh_in),
        .byte_in   (rx_byte_i),
        .shift_out (sh_out),
        .data      (sh_data)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            status     <= BUS_OK;
            is_write   <= 1'b0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= 4'h0;
            tx_valid_o <= 1'b0;
            tx_byte_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid_i && is_cmd) begin
                        is_write <= (rx_byte_i == CMD_WRITE);
                        byte_cnt <= '0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (rx_valid_i) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wb_adr_o <= {sh_data[23:0], rx_byte_i};
                            if (is_write) begin
                                state <= ST_WDATA;
                            end else begin
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_we_o  <= 1'b0;
                                wb_sel_o <= 4'hF;
                                tmo_cnt  <= '0;
                                state    <= ST_REQ;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (rx_valid_i) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wb_dat_o <= {sh_data[23:0], rx_byte_i};
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            wb_sel_o <= 4'hF;
                            tmo_cnt  <= '0;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // A response in the final allowed cycle still wins over the timeout.
                    if (bus_done) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        status     <= wb_err_i ? BUS_ERR : BUS_OK;
                        tx_byte_o  <= status_byte(wb_err_i ? BUS_ERR : BUS_OK);
                        tx_valid_o <= 1'b1;
                        state      <= ST_RESP_HDR;
                    end else if (tmo_cnt == TMO_LAST) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        status     <= BUS_TIMEOUT;
                        tx_byte_o  <= status_byte(BUS_TIMEOUT);
                        tx_valid_o <= 1'b1;
                        state      <= ST_RESP_HDR;
                    end else if (state == ST_REQ && !wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_RESP_HDR: begin
                    if (tx_fire) begin
                        if (status == BUS_OK && !is_write) begin
                            tx_byte_o <= sh_data[31:24];
                            byte_cnt  <= '0;
                            state     <= ST_RESP_DATA;
                        end else begin
                            tx_valid_o <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                ST_RESP_DATA: begin
                    if (tx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            tx_valid_o <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            tx_byte_o <= sh_data[31:24];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb/tb_uart_wb_bridge.sv - randomized self-checking bench for uart_wb_bridge with a transaction-level reference
module tb_uart_wb_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        stall, ack, err;
    logic        busy;

    always #5 clk = ~clk;

    uart_wb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .rx_byte_i  (rx_byte),
        .rx_valid_i (rx_valid),
        .tx_byte_o  (tx_byte),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .wb_cyc_o   (cyc),
        .wb_stb_o   (stb),
        .wb_we_o    (we),
        .wb_adr_o   (adr),
        .wb_dat_o   (dat_o),
        .wb_sel_o   (sel),
        .wb_stall_i (stall),
        .wb_ack_i   (ack),
        .wb_err_i   (err),
        .wb_dat_i   (dat_i),
        .busy_o     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // slave behaviour knobs: kind 0=ack 1=err 2=ack+err 3=silent
    int          cfg_stall = 0;
    int          cfg_lat = 0;
    int          cfg_kind = 3;
    bit          cfg_spur = 0;
    bit          cfg_rdy_rand = 0;
    logic [31:0] cfg_rdata = '0;
    logic [31:0] exp_adr = '0;
    logic [31:0] exp_wdat = '0;
    logic        exp_we = 1'b0;

    int          cyc_no = 0;
    int          cyc_cnt = 0;
    int          cyc_cycles, stb_cycles, accepts, bus_unstable, tx_unstable;
    int          t_ack, t_hdr;
    logic [31:0] acc_adr, acc_dat;
    logic        acc_we;
    logic [3:0]  acc_sel;
    logic [7:0]  txq[$];
    logic        prev_hold = 1'b0;
    logic        prev_valid = 1'b0;
    logic [7:0]  prev_byte = '0;

    // slave drive and monitor share one negedge block so the monitor sees this cycle's inputs
    always @(negedge clk) begin
        cyc_no++;
        if (cyc) cyc_cnt++; else cyc_cnt = 0;
        stall = cyc && stb && (cyc_cnt <= cfg_stall);
        ack = 1'b0;
        err = 1'b0;
        if (cyc && cfg_kind != 3 && cyc_cnt == cfg_stall + 1 + cfg_lat) begin
            ack   = (cfg_kind != 1);
            err   = (cfg_kind != 0);
            t_ack = cyc_no;
        end else if (stall && cfg_spur) begin
            ack = 1'b1;
        end
        dat_i    = ack ? cfg_rdata : $urandom;
        tx_ready = cfg_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

        if (cyc) begin
            cyc_cycles++;
            if (adr !== exp_adr || we !== exp_we || (exp_we && dat_o !== exp_wdat)) bus_unstable++;
        end
        if (cyc && stb) stb_cycles++;
        if (cyc && stb && !stall) begin
            accepts++;
            acc_adr = adr;
            acc_dat = dat_o;
            acc_we  = we;
            acc_sel = sel;
        end
        if (prev_hold && (!tx_valid || tx_byte !== prev_byte)) tx_unstable++;
        if (tx_valid && !prev_valid) t_hdr = cyc_no;
        if (tx_valid && tx_ready) txq.push_back(tx_byte);
        prev_hold  = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
        prev_valid = tx_valid;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic clear_stats();
        cyc_cycles = 0; stb_cycles = 0; accepts = 0; bus_unstable = 0; tx_unstable = 0;
        t_ack = -100; t_hdr = -1;
        txq.delete();
    endtask

    task automatic send_frame(input bit w, input logic [31:0] a, input logic [31:0] wd);
        send_byte(w ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        if (w) for (int i = 3; i >= 0; i--) send_byte(wd[8*i +: 8]);
    endtask

    task automatic run_txn(input string name, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int st, input int lat, input int kind,
                           input bit spur, input int garbage, input bit rdy_rand);
        logic [7:0] exp_q[$];
        bit tmo;
        int guard;
        int exp_stb;
        cfg_stall = st; cfg_lat = lat; cfg_kind = kind; cfg_spur = spur;
        cfg_rdy_rand = rdy_rand; cfg_rdata = rd;
        exp_adr = a; exp_we = w; exp_wdat = wd;
        clear_stats();
        tmo = (kind == 3) || (st + 1 + lat > TMO);
        exp_q.push_back(tmo ? 8'h54 : (kind != 0) ? 8'h45 : 8'h4B);
        if (!w && !tmo && kind == 0) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
        exp_stb = (st + 1 < TMO) ? st + 1 : TMO;

        if (garbage >= 0) send_byte(8'(garbage));
        send_frame(w, a, wd);
        send_byte(8'h00);
        guard = 0;
        while ((txq.size() < exp_q.size() || busy) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_done"}, 32'(guard < 400), 32'd1);
        repeat (3) @(negedge clk);
        check({name, "_tx_count"}, 32'(txq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
            check({name, "_tx_byte"}, 32'(txq[i]), 32'(exp_q[i]));
        check({name, "_accepts"}, 32'(accepts), (st + 1 <= TMO) ? 32'd1 : 32'd0);
        check({name, "_stb_cycles"}, 32'(stb_cycles), 32'(exp_stb));
        check({name, "_cyc_cycles"}, 32'(cyc_cycles), tmo ? 32'(TMO) : 32'(st + 1 + lat));
        if (st + 1 <= TMO) begin
            check({name, "_adr"}, acc_adr, a);
            check({name, "_we"}, 32'(acc_we), 32'(w));
            check({name, "_sel"}, 32'(acc_sel), 32'hF);
            if (w) check({name, "_wdat"}, acc_dat, wd);
        end
        check({name, "_bus_stable"}, 32'(bus_unstable), 32'd0);
        check({name, "_tx_stable"}, 32'(tx_unstable), 32'd0);
        if (!tmo) check({name, "_turnaround"}, 32'(t_hdr - t_ack), 32'd1);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int g;
        int r;
        int kind;
        int st;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_byte = '0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn("write", 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 0, 0, -1, 0);
        run_txn("read", 0, 32'h8000, 32'h0, 32'h12345678, 0, 1, 0, 0, -1, 1);
        run_txn("stall", 1, $urandom, $urandom, 32'h0, 5, 1, 0, 1, -1, 1);
        run_txn("timeout", 0, $urandom, 32'h0, $urandom, 0, 0, 3, 0, -1, 1);
        run_txn("garbage_err", 0, $urandom, 32'h0, $urandom, 0, 1, 2, 0, 8'h41, 1);

        // reset while waiting for the slave response
        cfg_stall = 0; cfg_lat = 6; cfg_kind = 0; cfg_spur = 0; cfg_rdy_rand = 0;
        exp_adr = 32'hA5A50004; exp_we = 1'b0;
        clear_stats();
        send_frame(0, 32'hA5A50004, 32'h0);
        g = 0;
        while (!(cyc && !stb) && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("rst_wait_reached", 32'(g < 50), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait_cyc", 32'(cyc), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_wait_no_tx", 32'(txq.size()), 32'd0);
        check("rst_wait_busy", 32'(busy), 32'd0);
        run_txn("after_rst", 0, $urandom, 32'h0, $urandom, 1, 2, 0, 0, -1, 1);

        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            kind = (r <= 5) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 3);
            g = $urandom_range(0, 1) ? -1 : $urandom_range(0, 255);
            if (g == 32'h57 || g == 32'h52) g = 8'h41;
            run_txn("rand", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, st,
                    $urandom_range(0, 3), kind, 1'($urandom_range(0, 1)), g, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
